fmul_share_arbiter: RTL and testbench

- Shares one float64_mul core (ap_start/ap_done/ap_idle/ap_ready handshake, 64-bit a/b, 64-bit ap_return) among NREQ requesters.
- Arbitration is round-robin, with one operation in flight at a time.
- Registers the granted operands, sequences the core's start/done handshake and returns the result to the granted requester as a one-cycle response pulse.
- Sits between the HLS-generated kernel loops and the single shared multiplier instance.

---
 rtl/fmul_share_arbiter_if.sv | 39 +++
 rtl/fmul_share_arbiter.sv | 146 ++++++++++++++
 tb/tb_fmul_share_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmul_share_arbiter_if.sv
// Bundle between the requesters/float64_mul core and the arbiter; state is carried for debug.
// slave is the arbiter side, master is the requester-and-core side.
interface fmul_share_arbiter_if #(
   parameter int NREQ = 4,
   parameter int GW   = 3
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [64*NREQ-1:0]   req_a;
   logic [64*NREQ-1:0]   req_b;
   logic [NREQ-1:0]      rsp_valid;
   logic [63:0]          rsp_data;
   logic                 rsp_err;
   logic                 core_start;
   logic [63:0]          core_a;
   logic [63:0]          core_b;
   logic                 core_ready;
   logic                 core_done;
   logic [63:0]          core_return;
   logic                 busy;
   logic [GW-1:0]        grant_id;
   logic [31:0]          op_cnt;
   logic [1:0]           fsm_state;

   // Handshakes: a request is accepted on the rising edge where req_valid[i] & req_ready[i];
   // the core accepts an op on the edge where core_start & core_ready, and its result is taken
   // on the edge where core_done is high; rsp_valid is a single-cycle pulse with no back-pressure.
   modport slave (
      input  req_valid, req_a, req_b, core_ready, core_done, core_return,
      output req_ready, rsp_valid, rsp_data, rsp_err, core_start, core_a, core_b,
             busy, grant_id, op_cnt, fsm_state
   );

   modport master (
      output req_valid, req_a, req_b, core_ready, core_done, core_return,
      input  req_ready, rsp_valid, rsp_data, rsp_err, core_start, core_a, core_b,
             busy, grant_id, op_cnt, fsm_state
   );
endinterface

// File: rtl/fmul_share_arbiter.sv
// Round-robin sharing of one float64_mul core among NREQ requesters, one op in flight.
// Optional watchdog: define FMUL_ARB_TIMEOUT_EN to abandon a core op after TIMEOUT_CYC cycles.
module fmul_share_arbiter #(
   parameter int NREQ        = 4,
   parameter int GW          = 3,
   parameter int TIMEOUT_CYC = 255
) (
   input logic                 ap_clk,
   input logic                 ap_rst_n,
   fmul_share_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

   if ((1 << GW) < NREQ || NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("fmul_share_arbiter: unsupported NREQ/GW/TIMEOUT_CYC combination");
   end

   state_t        state;
   logic [GW-1:0] rr_ptr;
   logic [GW-1:0] grant_q;
   logic [GW-1:0] pick;
   logic [GW-1:0] next_ptr;
   logic          core_start_q;
   logic [63:0]   core_a_q;
   logic [63:0]   core_b_q;
   logic [63:0]   rsp_data_q;
   logic [63:0]   sel_a;
   logic [63:0]   sel_b;
   logic [31:0]   op_cnt_q;
   logic          any_req;
   logic          timeout_hit;
   int            idx;

   // First valid requester at or above rr_ptr, wrapping past NREQ-1 back to 0.
   always_comb begin
      any_req = 1'b0;
      pick    = '0;
      idx     = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!any_req && bus.req_valid[idx]) begin
            any_req = 1'b1;
            pick    = GW'(idx);
         end
      end
   end

   assign sel_a    = bus.req_a[64*int'(pick) +: 64];
   assign sel_b    = bus.req_b[64*int'(pick) +: 64];
   assign next_ptr = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

   always_comb begin
      bus.req_ready = '0;
      if (state == IDLE && any_req) bus.req_ready[pick] = 1'b1;
   end

   always_comb begin
      bus.rsp_valid = '0;
      if (state == RESP) bus.rsp_valid[grant_q] = 1'b1;
   end

`ifdef FMUL_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] tmo_cnt;
   logic          rsp_err_q;
   assign timeout_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
   assign bus.rsp_err = rsp_err_q;
`else
   assign timeout_hit = 1'b0;
   assign bus.rsp_err = 1'b0;
`endif

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         grant_q      <= '0;
         core_start_q <= 1'b0;
         core_a_q     <= '0;
         core_b_q     <= '0;
         rsp_data_q   <= '0;
         op_cnt_q     <= '0;
`ifdef FMUL_ARB_TIMEOUT_EN
         tmo_cnt      <= '0;
         rsp_err_q    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  core_a_q     <= sel_a;
                  core_b_q     <= sel_b;
                  grant_q      <= pick;
                  core_start_q <= 1'b1;
                  state        <= START;
`ifdef FMUL_ARB_TIMEOUT_EN
                  tmo_cnt      <= '0;
`endif
               end
            end
            START, WAIT: begin
               // In START a done only counts together with ready; earlier ones are ignored.
               if (bus.core_done && (state == WAIT || bus.core_ready)) begin
                  core_start_q <= 1'b0;
                  rsp_data_q   <= bus.core_return;
                  state        <= RESP;
`ifdef FMUL_ARB_TIMEOUT_EN
                  rsp_err_q    <= 1'b0;
`endif
               end else if (timeout_hit) begin
                  core_start_q <= 1'b0;
                  rsp_data_q   <= '0;
                  state        <= RESP;
`ifdef FMUL_ARB_TIMEOUT_EN
                  rsp_err_q    <= 1'b1;
`endif
               end else begin
                  if (state == START && bus.core_ready) begin
                     core_start_q <= 1'b0;
                     state        <= WAIT;
                  end
`ifdef FMUL_ARB_TIMEOUT_EN
                  tmo_cnt <= tmo_cnt + 1'b1;
`endif
               end
            end
            RESP: begin
               op_cnt_q <= op_cnt_q + 32'd1;
               rr_ptr   <= next_ptr;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.core_start = core_start_q;
   assign bus.core_a     = core_a_q;
   assign bus.core_b     = core_b_q;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.busy       = (state != IDLE);
   assign bus.grant_id   = grant_q;
   assign bus.op_cnt     = op_cnt_q;
   assign bus.fsm_state  = state;
endmodule

// File: tb/tb_fmul_share_arbiter.sv
// Randomized bench for fmul_share_arbiter: requester driver, float64_mul core model,
// grant-order reference model feeding a response scoreboard, and a summary report.
module tb_fmul_share_arbiter;
   localparam int NREQ = 4;
   localparam int GW   = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fmul_share_arbiter_if #(.NREQ(NREQ), .GW(GW)) bus ();

   fmul_share_arbiter #(.NREQ(NREQ), .GW(GW), .TIMEOUT_CYC(255)) dut (
      .ap_clk  (clk),
      .ap_rst_n(rst_n),
      .bus     (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Scoreboard entries are {requester index, expected product}.
   logic [GW+63:0] exp_q[$];
   int             n_grant = 0;
   int             n_rsp   = 0;
   int             rr_m    = 0;
   logic [63:0]    fly_a   = '0;
   logic [63:0]    fly_b   = '0;

   logic [63:0] op_a[NREQ][16];
   logic [63:0] op_b[NREQ][16];
   int          wr_ptr[NREQ] = '{default: 0};
   int          rd_ptr[NREQ] = '{default: 0};

   int cm_rdy_max = 2;
   int cm_lat_min = 1;
   int cm_lat_max = 3;
   bit cm_same    = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
      return $realtobits($bitstoreal(a) * $bitstoreal(b));
   endfunction

   function automatic logic [63:0] rnd_op();
      real r;
      r = real'($urandom_range(1, 4000)) / 16.0;
      if ($urandom_range(0, 1) == 1) r = -r;
      return $realtobits(r);
   endfunction

   task automatic issue(input int i, input logic [63:0] a, input logic [63:0] b);
      op_a[i][wr_ptr[i] % 16] = a;
      op_b[i][wr_ptr[i] % 16] = b;
      wr_ptr[i]++;
   endtask

   // Requester driver: keeps req_valid high while a requester has queued work.
   initial begin
      logic [NREQ-1:0] acc;
      acc           = '0;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) rd_ptr[i]++;
            if (rd_ptr[i] < wr_ptr[i]) begin
               bus.req_valid[i]       = 1'b1;
               bus.req_a[64*i +: 64]  = op_a[i][rd_ptr[i] % 16];
               bus.req_b[64*i +: 64]  = op_b[i][rd_ptr[i] % 16];
            end else begin
               bus.req_valid[i] = 1'b0;
            end
         end
         #1;
         acc = rst_n ? (bus.req_valid & bus.req_ready) : '0;
      end
   end

   // Core model: random ready delay, then done either with ready or a few cycles later.
   initial begin
      int          ph;
      int          cnt;
      logic [63:0] ret;
      ph = 0; cnt = 0; ret = '0;
      bus.core_ready  = 1'b0;
      bus.core_done   = 1'b0;
      bus.core_return = '0;
      forever begin
         @(negedge clk);
         bus.core_ready = 1'b0;
         bus.core_done  = 1'b0;
         if (!rst_n) begin
            ph = 0;
         end else begin
            if (ph == 0 && bus.core_start) begin
               cnt = $urandom_range(0, cm_rdy_max);
               ph  = 1;
            end
            if (ph == 1) begin
               if (cnt > 0) begin
                  cnt--;
               end else begin
                  chk("core_a", bus.core_a, fly_a);
                  chk("core_b", bus.core_b, fly_b);
                  ret            = fmul(bus.core_a, bus.core_b);
                  bus.core_ready = 1'b1;
                  if (cm_same) begin
                     bus.core_done   = 1'b1;
                     bus.core_return = ret;
                     ph              = 0;
                  end else begin
                     cnt = $urandom_range(cm_lat_min, cm_lat_max) - 1;
                     ph  = 2;
                  end
               end
            end else if (ph == 2) begin
               if (cnt > 0) begin
                  cnt--;
               end else begin
                  bus.core_done   = 1'b1;
                  bus.core_return = ret;
                  ph              = 0;
               end
            end
         end
      end
   end

   // Reference model: when idle with pending requests, the next grant is the first valid
   // requester at or after the pointer (wrapping); the pointer then moves past the winner.
   initial begin
      int          g;
      logic [63:0] a;
      logic [63:0] b;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            exp_q.delete();
            n_grant = n_rsp;
            rr_m    = 0;
         end else if (n_grant != n_rsp) begin
            chk("ready_while_busy", bus.req_ready, 0);
         end else if (bus.req_valid == '0) begin
            chk("ready_without_req", bus.req_ready, 0);
         end else begin
            g = -1;
            for (int k = 0; k < NREQ; k++)
               if (g < 0 && bus.req_valid[(rr_m + k) % NREQ]) g = (rr_m + k) % NREQ;
            chk("grant", bus.req_ready, 128'(1) << g);
            a = bus.req_a[64*g +: 64];
            b = bus.req_b[64*g +: 64];
            exp_q.push_back({GW'(g), fmul(a, b)});
            fly_a   = a;
            fly_b   = b;
            rr_m    = (g + 1) % NREQ;
            n_grant++;
         end
      end
   end

   // Response monitor.
   initial begin
      logic [GW+63:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && bus.rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_rsp: rsp_valid=%b required=none outstanding", bus.rsp_valid);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_valid", bus.rsp_valid, 128'(1) << e[GW+63:64]);
               chk("rsp_data", bus.rsp_data, e[63:0]);
               chk("rsp_err", bus.rsp_err, 0);
               n_rsp++;
            end
         end
      end
   end

   task automatic wait_rsp(input int target, input string name);
      int t;
      t = 0;
      while (n_rsp < target && t < 3000) begin
         @(posedge clk);
         t++;
      end
      chk(name, n_rsp, target);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      int ops;
      int t;
      int bcnt;
      int r;

      repeat (3) @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_grant_id", bus.grant_id, 0);
      chk("rst_op_cnt", bus.op_cnt, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      chk("rst_core_start", bus.core_start, 0);
      chk("rst_core_a", bus.core_a, 0);

      // All four requesters valid from reset, two ops each: grants 0,1,2,3,0,1,2,3.
      for (int i = 0; i < NREQ; i++) begin
         issue(i, rnd_op(), rnd_op());
         issue(i, rnd_op(), rnd_op());
      end
      @(negedge clk);
      rst_n = 1'b1;
      wait_rsp(8, "rr_round_done");
      chk("rr_op_cnt", bus.op_cnt, 8);
      chk("rr_last_grant", bus.grant_id, 3);

      // Single op: 2.0 * 3.0.
      issue(0, 64'h4000000000000000, 64'h4008000000000000);
      wait_rsp(9, "single_done");
      chk("single_rsp_data", bus.rsp_data, 64'h4018000000000000);
      chk("single_op_cnt", bus.op_cnt, 9);
      chk("single_grant_id", bus.grant_id, 0);
      ops = 9;

      // Ready and done together: START goes straight to RESP, so busy lasts two cycles.
      cm_same    = 1'b1;
      cm_rdy_max = 0;
      base       = n_rsp;
      issue(2, rnd_op(), rnd_op());
      t = 0;
      while (!bus.busy && t < 50) begin @(negedge clk); t++; end
      bcnt = 0;
      while (bus.busy && bcnt < 50) begin @(negedge clk); bcnt++; end
      chk("same_cycle_busy_len", bcnt, 2);
      issue(1, rnd_op(), rnd_op());
      issue(3, rnd_op(), rnd_op());
      wait_rsp(base + 3, "same_cycle_done");
      ops += 3;

      // Random traffic with random core timing.
      cm_rdy_max = 3;
      cm_lat_max = 4;
      base       = n_rsp;
      r          = 0;
      for (int n = 0; n < 60; n++) begin
         @(posedge clk);
         cm_same = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 2) != 0) begin
            t = $urandom_range(0, NREQ - 1);
            if (wr_ptr[t] - rd_ptr[t] < 8) begin
               issue(t, rnd_op(), rnd_op());
               r++;
            end
         end
      end
      wait_rsp(base + r, "random_done");
      ops += r;
      chk("random_op_cnt", bus.op_cnt, 32'(ops));

      // Reset while waiting on a slow core: everything clears, no response appears.
      cm_same    = 1'b0;
      cm_rdy_max = 0;
      cm_lat_min = 20;
      cm_lat_max = 20;
      issue(1, rnd_op(), rnd_op());
      t = 0;
      while (!bus.busy && t < 50) begin @(negedge clk); t++; end
      repeat (3) @(negedge clk);
      chk("mid_op_busy", bus.busy, 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", bus.busy, 0);
      chk("arst_core_start", bus.core_start, 0);
      chk("arst_core_a", bus.core_a, 0);
      chk("arst_core_b", bus.core_b, 0);
      chk("arst_grant_id", bus.grant_id, 0);
      chk("arst_op_cnt", bus.op_cnt, 0);
      chk("arst_rsp_valid", bus.rsp_valid, 0);
      chk("arst_rsp_data", bus.rsp_data, 0);
      chk("arst_req_ready", bus.req_ready, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      cm_lat_min = 1;
      cm_lat_max = 3;
      base       = n_rsp;
      issue(2, rnd_op(), rnd_op());
      issue(0, rnd_op(), rnd_op());
      wait_rsp(base + 2, "post_reset_done");
      chk("post_reset_op_cnt", bus.op_cnt, 2);
      chk("post_reset_last_grant", bus.grant_id, 2);

      // Counter wrap.
      @(negedge clk);
      force dut.op_cnt_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.op_cnt_q;
      #1;
      chk("preload_op_cnt", bus.op_cnt, 32'hFFFF_FFFF);
      base = n_rsp;
      issue(3, rnd_op(), rnd_op());
      wait_rsp(base + 1, "wrap_done");
      chk("wrap_op_cnt", bus.op_cnt, 0);

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: sim time expired, required finish before 2000000");
      $fatal(1, "watchdog");
   end
endmodule
